sqrt_pipe: RTL and testbench

Fully pipelined, parametrised unsigned integer square root with valid/tag sideband and a global stall enable. Successor to the fixed-latency square-root macro in the DSP operation library. Accepts one radical per clock and returns floor root and remainder after a fixed latency. Used wherever magnitude or norm computation needs sustained throughput, for example after an I²+Q² accumulator.

---
 rtl/sqrt_pipe.sv | 136 +++++++++++++
 tb/tb_sqrt_pipe.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_pipe.sv
// Pipelined unsigned integer square root (restoring digit recurrence) with valid/tag sideband.
// Define SQRT_PIPE_ROUND_EN to add a registered round-to-nearest output stage.
module sqrt_pipe #(
  parameter  int WIDTH          = 16,
  parameter  int BITS_PER_STAGE = 1,
  parameter  int TAG_WIDTH      = 4,
  localparam int QW             = (WIDTH + 1) / 2,
  localparam int RW             = QW + 1
) (
  input  logic                 clk,
  input  logic                 aclr,
  input  logic                 ena,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     radical,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  output logic [QW-1:0]        q,
  output logic [RW-1:0]        remainder,
  output logic [TAG_WIDTH-1:0] out_tag
);

  localparam int NSTAGE = QW / BITS_PER_STAGE;
  localparam int DW     = 2 * QW;
  localparam int L      = NSTAGE - 1;

  logic [NSTAGE-1:0]    v_r;
  logic [QW-1:0]        q_r [NSTAGE];
  logic [RW:0]          r_r [NSTAGE];
  logic [DW-1:0]        d_r [NSTAGE];
  logic [TAG_WIDTH-1:0] t_r [NSTAGE];

  logic [QW-1:0]        q_s [NSTAGE];
  logic [RW:0]          r_s [NSTAGE];
  logic [DW-1:0]        d_s [NSTAGE];
  logic [QW-1:0]        q_n [NSTAGE];
  logic [RW:0]          r_n [NSTAGE];
  logic [DW-1:0]        d_n [NSTAGE];

  logic [QW-1:0]        qt;
  logic [RW:0]          rt, rp, tt;
  logic [DW-1:0]        dt;

  // Stage 0 starts from an empty root/remainder and the zero-extended radical.
  always_comb begin
    q_s[0] = '0;
    r_s[0] = '0;
    d_s[0] = DW'(radical);
    for (int unsigned s = 1; s < NSTAGE; s++) begin
      q_s[s] = q_r[s-1];
      r_s[s] = r_r[s-1];
      d_s[s] = d_r[s-1];
    end
  end

  always_comb begin
    qt = '0;
    rt = '0;
    rp = '0;
    tt = '0;
    dt = '0;
    for (int unsigned s = 0; s < NSTAGE; s++) begin
      qt = q_s[s];
      rt = r_s[s];
      dt = d_s[s];
      for (int unsigned i = 0; i < BITS_PER_STAGE; i++) begin
        rp = {rt[RW-2:0], dt[DW-1 -: 2]};
        tt = {qt, 2'b01};
        if (rp >= tt) begin
          rt = rp - tt;
          qt = QW'({qt, 1'b1});
        end else begin
          rt = rp;
          qt = QW'({qt, 1'b0});
        end
        dt = dt << 2;
      end
      q_n[s] = qt;
      r_n[s] = rt;
      d_n[s] = dt;
    end
  end

  // Data registers advance on every enabled edge; only the valid chain marks bubbles.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      v_r <= '0;
      for (int unsigned s = 0; s < NSTAGE; s++) begin
        q_r[s] <= '0;
        r_r[s] <= '0;
        d_r[s] <= '0;
        t_r[s] <= '0;
      end
    end else if (ena) begin
      v_r[0] <= in_valid;
      t_r[0] <= in_tag;
      for (int unsigned s = 0; s < NSTAGE; s++) begin
        q_r[s] <= q_n[s];
        r_r[s] <= r_n[s];
        d_r[s] <= d_n[s];
      end
      for (int unsigned s = 1; s < NSTAGE; s++) begin
        v_r[s] <= v_r[s-1];
        t_r[s] <= t_r[s-1];
      end
    end
  end

`ifdef SQRT_PIPE_ROUND_EN
  logic [RW-1:0] rem_f;
  logic [QW-1:0] q_f;

  assign rem_f = r_r[L][RW-1:0];
  assign q_f   = q_r[L];

  // Round up when remainder exceeds the floor root, holding at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      out_valid <= 1'b0;
      q         <= '0;
      remainder <= '0;
      out_tag   <= '0;
    end else if (ena) begin
      out_valid <= v_r[L];
      remainder <= rem_f;
      out_tag   <= t_r[L];
      q         <= ((rem_f > RW'(q_f)) && (q_f != '1)) ? q_f + 1'b1 : q_f;
    end
  end
`else
  assign out_valid = v_r[L];
  assign q         = q_r[L];
  assign remainder = r_r[L][RW-1:0];
  assign out_tag   = t_r[L];
`endif

endmodule

// File: tb/tb_sqrt_pipe.sv
// Scoreboard bench for sqrt_pipe: default, BITS_PER_STAGE=2/4 and WIDTH=9 instances.
// Honours SQRT_PIPE_ROUND_EN for expected root and latency.
module tb_sqrt_pipe;

`ifdef SQRT_PIPE_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif
  localparam int LAT_M = 8 + RND;
  localparam int LAT_2 = 4 + RND;
  localparam int LAT_4 = 2 + RND;
  localparam int LAT_W = 5 + RND;

  typedef struct {
    logic [7:0] q;
    logic [8:0] r;
    logic [3:0] tag;
    int         due;
  } exp_t;

  typedef struct {
    logic [15:0] x;
    logic [7:0]  qf;
    logic [7:0]  qr;
    logic [8:0]  r;
  } vec_t;

  logic        clk = 1'b0;
  logic        aclr = 1'b1;
  logic        ena = 1'b1;
  logic        iv = 1'b0;
  logic        iv9 = 1'b0;
  logic [15:0] rad = '0;
  logic [8:0]  rad9 = '0;
  logic [3:0]  tag = '0;

  logic        m_ov, b2_ov, b4_ov, w9_ov;
  logic [7:0]  m_q, b2_q, b4_q;
  logic [8:0]  m_r, b2_r, b4_r;
  logic [3:0]  m_t, b2_t, b4_t, w9_t;
  logic [4:0]  w9_q;
  logic [5:0]  w9_r;

  exp_t sb_m[$], sb_2[$], sb_4[$], sb_w[$];
  int   total = 0, bad = 0;
  int   cyc = 0, en_edges = 0, last_main_cyc = 0, c0 = 0;
  bit   fresh = 1'b0;

  vec_t first_set [7] = '{
    '{16'd0,     8'd0,   8'd0,   9'd0},
    '{16'd1,     8'd1,   8'd1,   9'd0},
    '{16'd144,   8'd12,  8'd12,  9'd0},
    '{16'd143,   8'd11,  8'd12,  9'd22},
    '{16'd65535, 8'd255, 8'd255, 9'd510},
    '{16'd40000, 8'd200, 8'd200, 9'd0},
    '{16'd156,   8'd12,  8'd12,  9'd12}
  };

  vec_t stream [10] = '{
    '{16'd2,     8'd1,   8'd1,   9'd1},
    '{16'd3,     8'd1,   8'd2,   9'd2},
    '{16'd10,    8'd3,   8'd3,   9'd1},
    '{16'd99,    8'd9,   8'd10,  9'd18},
    '{16'd100,   8'd10,  8'd10,  9'd0},
    '{16'd1000,  8'd31,  8'd32,  9'd39},
    '{16'd4095,  8'd63,  8'd64,  9'd126},
    '{16'd30000, 8'd173, 8'd173, 9'd71},
    '{16'd50000, 8'd223, 8'd224, 9'd271},
    '{16'd65280, 8'd255, 8'd255, 9'd255}
  };

  sqrt_pipe u_dut (
    .clk(clk), .aclr(aclr), .ena(ena), .in_valid(iv), .radical(rad), .in_tag(tag),
    .out_valid(m_ov), .q(m_q), .remainder(m_r), .out_tag(m_t)
  );

  sqrt_pipe #(.BITS_PER_STAGE(2)) u_b2 (
    .clk(clk), .aclr(aclr), .ena(ena), .in_valid(iv), .radical(rad), .in_tag(tag),
    .out_valid(b2_ov), .q(b2_q), .remainder(b2_r), .out_tag(b2_t)
  );

  sqrt_pipe #(.BITS_PER_STAGE(4)) u_b4 (
    .clk(clk), .aclr(aclr), .ena(ena), .in_valid(iv), .radical(rad), .in_tag(tag),
    .out_valid(b4_ov), .q(b4_q), .remainder(b4_r), .out_tag(b4_t)
  );

  sqrt_pipe #(.WIDTH(9)) u_w9 (
    .clk(clk), .aclr(aclr), .ena(ena), .in_valid(iv9), .radical(rad9), .in_tag(tag),
    .out_valid(w9_ov), .q(w9_q), .remainder(w9_r), .out_tag(w9_t)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    fresh = ena && !aclr;
    if (fresh) en_edges++;
  end

  task automatic chk(input string nm, input exp_t e, input logic [7:0] aq,
                     input logic [8:0] ar, input logic [3:0] at);
    total++;
    if (aq !== e.q || ar !== e.r || at !== e.tag || en_edges != e.due) begin
      bad++;
      $display("FAIL %s: got q=%0d r=%0d tag=%0d edge=%0d, expected q=%0d r=%0d tag=%0d edge=%0d",
               nm, aq, ar, at, en_edges, e.q, e.r, e.tag, e.due);
    end
  endtask

  task automatic unexp(input string nm, input logic [3:0] at);
    total++;
    bad++;
    $display("FAIL %s: unexpected output tag=%0d at edge=%0d, expected none", nm, at, en_edges);
  endtask

  task automatic chk_val(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, want);
    end
  endtask

  always @(negedge clk) if (fresh && m_ov) begin
    last_main_cyc = cyc;
    if (sb_m.size() == 0) unexp("main", m_t);
    else chk("main", sb_m.pop_front(), m_q, m_r, m_t);
  end

  always @(negedge clk) if (fresh && b2_ov) begin
    if (sb_2.size() == 0) unexp("bps2", b2_t);
    else chk("bps2", sb_2.pop_front(), b2_q, b2_r, b2_t);
  end

  always @(negedge clk) if (fresh && b4_ov) begin
    if (sb_4.size() == 0) unexp("bps4", b4_t);
    else chk("bps4", sb_4.pop_front(), b4_q, b4_r, b4_t);
  end

  always @(negedge clk) if (fresh && w9_ov) begin
    if (sb_w.size() == 0) unexp("w9", w9_t);
    else chk("w9", sb_w.pop_front(), {3'b0, w9_q}, {3'b0, w9_r}, w9_t);
  end

  task automatic send(input vec_t v, input logic [3:0] tg);
    logic [7:0] eq;
    eq = (RND != 0) ? v.qr : v.qf;
    @(negedge clk);
    ena = 1'b1;
    iv  = 1'b1;
    rad = v.x;
    tag = tg;
    sb_m.push_back('{eq, v.r, tg, en_edges + LAT_M});
    sb_2.push_back('{eq, v.r, tg, en_edges + LAT_2});
    sb_4.push_back('{eq, v.r, tg, en_edges + LAT_4});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      ena = 1'b1;
      iv  = 1'b0;
      iv9 = 1'b0;
    end
  endtask

  task automatic chk_zero(input string pfx);
    chk_val({pfx, "_valid"}, int'(m_ov), 0);
    chk_val({pfx, "_q"}, int'(m_q), 0);
    chk_val({pfx, "_rem"}, int'(m_r), 0);
    chk_val({pfx, "_tag"}, int'(m_t), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_zero("reset");
    #2 aclr = 1'b0;

    for (int i = 0; i < 7; i++) send(first_set[i], 4'(i));
    idle(12);

    @(negedge clk);
    iv9 = 1'b1; rad9 = 9'd511; tag = 4'd1;
    sb_w.push_back('{(RND != 0) ? 8'd23 : 8'd22, 9'd27, 4'd1, en_edges + LAT_W});
    @(negedge clk);
    rad9 = 9'd256; tag = 4'd2;
    sb_w.push_back('{8'd16, 9'd0, 4'd2, en_edges + LAT_W});
    idle(10);

    send(stream[0], 4'd5);
    c0 = cyc;
    for (int i = 1; i < 5; i++) send(stream[i], 4'(5 + i));
    repeat (3) begin
      @(negedge clk);
      ena = 1'b0; iv = 1'b1; rad = 16'd7; tag = 4'd15;
    end
    for (int i = 5; i < 10; i++) send(stream[i], 4'(5 + i));
    idle(14);
    chk_val("stall_last_cycle", last_main_cyc, c0 + 12 + LAT_M);

    for (int i = 0; i < 10; i++) send(stream[i], 4'(5 + i));
    @(negedge clk);
    iv = 1'b0;
    #2 aclr = 1'b1;
    #1 chk_zero("async_clr");
    sb_m.delete();
    sb_2.delete();
    sb_4.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 aclr = 1'b0;
    idle(12);
    send(first_set[3], 4'd3);
    idle(12);

    chk_val("main_drained", sb_m.size(), 0);
    chk_val("bps2_drained", sb_2.size(), 0);
    chk_val("bps4_drained", sb_4.size(), 0);
    chk_val("w9_drained", sb_w.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
